// File: rtl/mem_responder.sv
// mem_responder: word-addressed main-memory responder on the CPU memory bus.
//
// A request is sampled in IDLE from control_signals (bit 1 = MEM_RD,
// bit 2 = MEM_WR; a write wins when both are set). Address and write data
// are latched at that edge. The FSM then spends WAIT_CYCLES extra edges in
// WAIT, performs the access on the edge where the counter reaches zero, and
// signals completion with a one-cycle mem_ready pulse from DONE.
//
// Optional feature macro: MEM_WRITE_GUARD_EN
//   When defined, writes to addresses >= PROT_BASE are dropped and the
//   wr_fault port pulses together with mem_ready for such writes.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   control_signals in   [15:0] control-unit word (bits 1/2 used)
//   mar_data        in   [ADDR_W-1:0] access address
//   mbr2mem         in   [DATA_W-1:0] write data
//   mem2mbr         out  [DATA_W-1:0] read data register
//   mem_ready       out  one-cycle completion pulse
//   mem_busy        out  high while the FSM is not IDLE
//   wr_fault        out  protected-write flag (MEM_WRITE_GUARD_EN only)
module mem_responder #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 8,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] PROT_BASE   = ADDR_W'(8'hF0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       control_signals,
    input  logic [ADDR_W-1:0] mar_data,
    input  logic [DATA_W-1:0] mbr2mem,
    output logic [DATA_W-1:0] mem2mbr,
    output logic              mem_ready,
    output logic              mem_busy
`ifdef MEM_WRITE_GUARD_EN
    ,
    output logic              wr_fault
`endif
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              is_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic rd_req;
    logic wr_req;
    logic access;
    logic prot;
    logic commit;

    assign rd_req = control_signals[1];
    assign wr_req = control_signals[2];

    // Remaining control bits belong to other units.
    logic unused_ctrl;
    assign unused_ctrl = ^{control_signals[15:3], control_signals[0]};

`ifdef MEM_WRITE_GUARD_EN
    assign prot = (addr >= PROT_BASE);
`else
    assign prot = 1'b0;
    logic unused_prot;
    assign unused_prot = ^PROT_BASE;
`endif

    // Access edge: last WAIT edge. Reset forces IDLE asynchronously, so an
    // aborted access can never reach this point and never commits.
    assign access = (state == WAIT) && (cnt == 4'd0);
    assign commit = access && is_wr && !prot;

    // Array has no reset; only the committed write port touches it.
    always_ff @(posedge clk) begin
        if (commit)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr      <= '0;
            wdata     <= '0;
            is_wr     <= 1'b0;
            mem2mbr   <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
`ifdef MEM_WRITE_GUARD_EN
            wr_fault  <= 1'b0;
`endif
        end else begin
            mem_ready <= 1'b0;
`ifdef MEM_WRITE_GUARD_EN
            wr_fault  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        addr     <= mar_data;
                        wdata    <= mbr2mem;
                        is_wr    <= wr_req;
                        cnt      <= CNT_INIT;
                        state    <= WAIT;
                        mem_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Read-after-write sees the new word: the write
                        // committed on an earlier access edge.
                        if (!is_wr)
                            mem2mbr <= mem[addr];
                        mem_ready <= 1'b1;
`ifdef MEM_WRITE_GUARD_EN
                        wr_fault  <= is_wr && prot;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
